// File: rtl/fp16_add_arbiter.sv
// rtl/fp16_add_arbiter.sv - two-requester round-robin sequencer for a shared multi-cycle fp16 adder
//
// Purpose: accepts one operand pair at a time from requester 0 or 1, launches the
// shared fp16 add datapath with a one-cycle start pulse, waits for done and
// returns the sum and exception flag to the requester that owns the transaction.
//
// Ports:
//   CLK, RST                       clock (rising edge), asynchronous active-high reset
//   IN_REQx_VALID / OUT_REQx_READY request handshake, IN_REQx_A/B operands (x = 0,1)
//   OUT_RSPx_VALID / IN_RSPx_READY response handshake, OUT_RSPx_RESULT/EXC payload
//   OUT_DP_START, OUT_DP_A/B       launch pulse and operands to the datapath
//   IN_DP_DONE, IN_DP_RESULT/EXC   datapath completion pulse and payload
//   OUT_BUSY                       high whenever a transaction is in progress
//
// Optional feature macro: FP16_ARB_TIMEOUT_EN
//   When defined, a watchdog ends WAIT after TIMEOUT_CYCLES cycles without done,
//   returning qNaN (16'h7E00) with the exception flag set.

module fp16_add_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_REQ0_VALID,
  output logic        OUT_REQ0_READY,
  input  logic [15:0] IN_REQ0_A,
  input  logic [15:0] IN_REQ0_B,
  input  logic        IN_REQ1_VALID,
  output logic        OUT_REQ1_READY,
  input  logic [15:0] IN_REQ1_A,
  input  logic [15:0] IN_REQ1_B,
  output logic        OUT_RSP0_VALID,
  input  logic        IN_RSP0_READY,
  output logic [15:0] OUT_RSP0_RESULT,
  output logic        OUT_RSP0_EXC,
  output logic        OUT_RSP1_VALID,
  input  logic        IN_RSP1_READY,
  output logic [15:0] OUT_RSP1_RESULT,
  output logic        OUT_RSP1_EXC,
  output logic        OUT_DP_START,
  output logic [15:0] OUT_DP_A,
  output logic [15:0] OUT_DP_B,
  input  logic        IN_DP_DONE,
  input  logic [15:0] IN_DP_RESULT,
  input  logic        IN_DP_EXC,
  output logic        OUT_BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nx;
  logic [15:0] op_a, op_b, res_q;
  logic        exc_q, owner, last_grant;
  logic        grant0, grant1;
  logic        timeout;

  // Ties go to the requester that was not granted last. READY is held low
  // during reset so no handshake appears while the block is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE && !RST) begin
      if (IN_REQ0_VALID && (!IN_REQ1_VALID || last_grant))
        grant0 = 1'b1;
      else if (IN_REQ1_VALID)
        grant1 = 1'b1;
    end
  end

`ifdef FP16_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Counter holds the number of completed WAIT cycles; timeout fires during
  // the last allowed WAIT cycle so RESP follows exactly TIMEOUT_CYCLES waits.
  assign timeout = (state == S_WAIT) && !IN_DP_DONE &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      wait_cnt <= '0;
    else if (state == S_ISSUE)
      wait_cnt <= '0;
    else if (state == S_WAIT)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic [CNT_W-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx        = state;
    OUT_REQ0_READY  = grant0;
    OUT_REQ1_READY  = grant1;
    OUT_DP_START    = 1'b0;
    OUT_DP_A        = 16'h0000;
    OUT_DP_B        = 16'h0000;
    OUT_RSP0_VALID  = 1'b0;
    OUT_RSP0_RESULT = 16'h0000;
    OUT_RSP0_EXC    = 1'b0;
    OUT_RSP1_VALID  = 1'b0;
    OUT_RSP1_RESULT = 16'h0000;
    OUT_RSP1_EXC    = 1'b0;
    OUT_BUSY        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (grant0 || grant1)
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        OUT_DP_START = 1'b1;
        OUT_DP_A     = op_a;
        OUT_DP_B     = op_b;
        state_nx     = S_WAIT;
      end
      S_WAIT: begin
        OUT_DP_A = op_a;
        OUT_DP_B = op_b;
        if (IN_DP_DONE || timeout)
          state_nx = S_RESP;
      end
      S_RESP: begin
        if (owner) begin
          OUT_RSP1_VALID  = 1'b1;
          OUT_RSP1_RESULT = res_q;
          OUT_RSP1_EXC    = exc_q;
          if (IN_RSP1_READY)
            state_nx = S_IDLE;
        end else begin
          OUT_RSP0_VALID  = 1'b1;
          OUT_RSP0_RESULT = res_q;
          OUT_RSP0_EXC    = exc_q;
          if (IN_RSP0_READY)
            state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      res_q      <= 16'h0000;
      exc_q      <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant0 || grant1) begin
        op_a       <= grant1 ? IN_REQ1_A : IN_REQ0_A;
        op_b       <= grant1 ? IN_REQ1_B : IN_REQ0_B;
        owner      <= grant1;
        last_grant <= grant1;
      end
      // A done outside WAIT is stray and ignored; done beats a same-cycle timeout.
      if (state == S_WAIT) begin
        if (IN_DP_DONE) begin
          res_q <= IN_DP_RESULT;
          exc_q <= IN_DP_EXC;
        end else if (timeout) begin
          res_q <= 16'h7E00;
          exc_q <= 1'b1;
        end
      end
    end
  end

endmodule
